// File: rtl/mcp_instr_sequencer.sv
// Issue stage for the multi-cycle core: buffers instructions in a circular FIFO and
// issues them one at a time (start pulse, wait for done or timeout), capturing results.
module mcp_instr_sequencer #(
    parameter int unsigned INSTR_W = 18,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INSTR_W-1:0]           in_instr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         enable,
    output logic [INSTR_W-1:0]           instr,
    output logic                         start,
    input  logic                         done,
    input  logic [DATA_W-1:0]            mem_out,
    input  logic [DATA_W-1:0]            reg_out,
    output logic                         res_valid,
    output logic [DATA_W-1:0]            res_mem,
    output logic [DATA_W-1:0]            res_reg,
    output logic [15:0]                  retired_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         busy,
    output logic                         err_timeout,
    output logic                         err_spurious
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  fifo_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                start_q, start_d;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_mem_q, res_mem_d;
    logic [DATA_W-1:0]   res_reg_q, res_reg_d;
    logic [15:0]         retired_q, retired_d;
    logic                err_to_q, err_to_d;
    logic                err_sp_q, err_sp_d;
    logic                push, pop;

    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_IDLE) && enable && (level_q != '0);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        start_d     = 1'b0;
        res_valid_d = 1'b0;
        res_mem_d   = res_mem_q;
        res_reg_d   = res_reg_q;
        retired_d   = retired_q;
        err_to_d    = err_to_q;
        err_sp_d    = err_sp_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (done) err_sp_d = 1'b1;
                if (pop) begin
                    instr_d = fifo_q[rd_ptr_q];
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // done takes priority over an expiring timeout on the same edge
                if (done) begin
                    res_mem_d   = mem_out;
                    res_reg_d   = reg_out;
                    res_valid_d = 1'b1;
                    retired_d   = retired_q + 16'd1;
                    state_d     = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            instr_q     <= '0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_mem_q   <= '0;
            res_reg_q   <= '0;
            retired_q   <= '0;
            err_to_q    <= 1'b0;
            err_sp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            res_mem_q   <= res_mem_d;
            res_reg_q   <= res_reg_d;
            retired_q   <= retired_d;
            err_to_q    <= err_to_d;
            err_sp_q    <= err_sp_d;
        end
    end

    // Storage needs no reset: resetting the pointers and level flushes it.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= in_instr;
    end

    assign instr        = instr_q;
    assign start        = start_q;
    assign res_valid    = res_valid_q;
    assign res_mem      = res_mem_q;
    assign res_reg      = res_reg_q;
    assign retired_cnt  = retired_q;
    assign level        = level_q;
    assign busy         = (state_q == S_WAIT);
    assign err_timeout  = err_to_q;
    assign err_spurious = err_sp_q;

endmodule

// File: tb/tb_mcp_instr_sequencer.sv
// Scoreboard bench for mcp_instr_sequencer: directed pushes, a scripted core responder,
// and a monitor that checks every start and res_valid against queued expectations.
module tb_mcp_instr_sequencer;

    logic        clk;
    logic        rst;
    logic [17:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        enable;
    logic [17:0] instr;
    logic        start;
    logic        done;
    logic [7:0]  mem_out;
    logic [7:0]  reg_out;
    logic        res_valid;
    logic [7:0]  res_mem;
    logic [7:0]  res_reg;
    logic [15:0] retired_cnt;
    logic [3:0]  level;
    logic        busy;
    logic        err_timeout;
    logic        err_spurious;

    logic        core_done;
    logic        spur_done;

    typedef struct {
        logic [7:0] m;
        logic [7:0] r;
        int         delay;
        bit         hang;
    } rsp_t;

    logic [17:0] exp_instr [$];
    logic [15:0] exp_res   [$];
    rsp_t        rsp_q     [$];

    int n_cmp = 0;
    int n_err = 0;

    assign done = core_done | spur_done;

    mcp_instr_sequencer #(
        .INSTR_W (18),
        .DATA_W  (8),
        .DEPTH   (8),
        .TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_instr     (in_instr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .enable       (enable),
        .instr        (instr),
        .start        (start),
        .done         (done),
        .mem_out      (mem_out),
        .reg_out      (reg_out),
        .res_valid    (res_valid),
        .res_mem      (res_mem),
        .res_reg      (res_reg),
        .retired_cnt  (retired_cnt),
        .level        (level),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge with in_valid low.
    task automatic push_op(input logic [17:0] ins, input bit accept, input logic [7:0] m,
                           input logic [7:0] r, input int delay, input bit hang);
        rsp_t e;
        in_instr = ins;
        in_valid = 1'b1;
        chk("in_ready", in_ready, accept);
        if (accept) begin
            e.m = m; e.r = r; e.delay = delay; e.hang = hang;
            exp_instr.push_back(ins);
            rsp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy && level == 4'd0 && !start) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1'b1);
    endtask

    task automatic wait_start(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (start) begin
                ok = 1'b1;
                break;
            end
        end
        chk("start_seen", ok, 1'b1);
    endtask

    // Core model: answers each start with the scripted delay and data.
    initial begin
        rsp_t e;
        core_done = 1'b0;
        mem_out   = '0;
        reg_out   = '0;
        forever begin
            @(negedge clk);
            if (!rst && start && rsp_q.size() > 0) begin
                e = rsp_q.pop_front();
                if (!e.hang) begin
                    repeat (e.delay - 1) @(negedge clk);
                    core_done = 1'b1;
                    mem_out   = e.m;
                    reg_out   = e.r;
                    exp_res.push_back({e.m, e.r});
                    @(negedge clk);
                    core_done = 1'b0;
                end
            end
        end
    end

    initial begin
        bit prev_start;
        bit prev_rv;
        prev_start = 1'b0;
        prev_rv    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 1'b0;
                prev_rv    = 1'b0;
            end else begin
                if (start) begin
                    chk("start_width", prev_start, 1'b0);
                    if (exp_instr.size() == 0) chk("unexpected_start", 1'b1, 1'b0);
                    else                       chk("instr", instr, exp_instr.pop_front());
                end
                if (res_valid) begin
                    chk("res_valid_width", prev_rv, 1'b0);
                    if (exp_res.size() == 0) chk("unexpected_res_valid", 1'b1, 1'b0);
                    else                     chk("result", {res_mem, res_reg}, exp_res.pop_front());
                end
                prev_start = start;
                prev_rv    = res_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_instr  = '0;
        in_valid  = 1'b0;
        enable    = 1'b0;
        spur_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", level, 4'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_start", start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_retired", retired_cnt, 16'd0);
        chk("rst_instr", instr, 18'd0);
        chk("rst_res_valid", res_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single op: start one edge after the push edge, done 5 cycles later.
        enable = 1'b1;
        push_op(18'h2A5F1, 1'b1, 8'h3C, 8'hA7, 5, 1'b0);
        chk("single_no_bypass", start, 1'b0);
        chk("single_level", level, 4'd1);
        @(negedge clk);
        chk("single_start", start, 1'b1);
        chk("single_busy", busy, 1'b1);
        wait_drain(20);
        chk("single_res_mem", res_mem, 8'h3C);
        chk("single_res_reg", res_reg, 8'hA7);
        chk("single_retired", retired_cnt, 16'd1);

        // Full FIFO: 9th push refused; drain in push order.
        enable = 1'b0;
        for (int i = 0; i < 9; i++)
            push_op(18'h10000 + 18'(i), (i < 8), 8'h10 + 8'(i), 8'h80 + 8'(i), 3, 1'b0);
        chk("full_level", level, 4'd8);
        chk("full_in_ready", in_ready, 1'b0);
        enable = 1'b1;
        wait_drain(100);
        chk("full_retired", retired_cnt, 16'd9);
        chk("full_level_empty", level, 4'd0);

        // Push and pop on the same edge: level unchanged, new entry issues last.
        enable = 1'b0;
        for (int i = 0; i < 7; i++)
            push_op(18'h20000 + 18'(i), 1'b1, 8'h40 + 8'(i), 8'hC0 + 8'(i), 2, 1'b0);
        chk("simul_level_before", level, 4'd7);
        enable = 1'b1;
        push_op(18'h3FFFF, 1'b1, 8'hEE, 8'h11, 2, 1'b0);
        chk("simul_level_after", level, 4'd7);
        chk("simul_start", start, 1'b1);
        wait_drain(100);
        chk("simul_retired", retired_cnt, 16'd17);

        // done on the timeout edge wins.
        push_op(18'h05555, 1'b1, 8'h99, 8'h66, 64, 1'b0);
        wait_drain(100);
        chk("tie_err_timeout", err_timeout, 1'b0);
        chk("tie_retired", retired_cnt, 16'd18);

        // done while idle.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_err", err_spurious, 1'b1);
        chk("spur_retired", retired_cnt, 16'd18);
        chk("spur_err_timeout", err_timeout, 1'b0);

        // Timeout on a hung core, then the next op issues normally.
        enable = 1'b0;
        push_op(18'h0F0F0, 1'b1, 8'h00, 8'h00, 0, 1'b1);
        push_op(18'h0A0A0, 1'b1, 8'h71, 8'h17, 2, 1'b0);
        enable = 1'b1;
        wait_start(10);
        repeat (63) @(negedge clk);
        chk("to_busy_pre", busy, 1'b1);
        chk("to_err_pre", err_timeout, 1'b0);
        @(negedge clk);
        chk("to_busy", busy, 1'b0);
        chk("to_err", err_timeout, 1'b1);
        chk("to_retired", retired_cnt, 16'd18);
        wait_drain(20);
        chk("to_next_retired", retired_cnt, 16'd19);

        // Reset mid-WAIT with 3 queued drops everything.
        push_op(18'h01111, 1'b1, 8'h00, 8'h00, 0, 1'b1);
        wait_start(10);
        for (int i = 0; i < 3; i++)
            push_op(18'h03000 + 18'(i), 1'b1, 8'h00, 8'h00, 2, 1'b0);
        chk("rst2_level_before", level, 4'd3);
        rst = 1'b1;
        exp_instr.delete();
        rsp_q.delete();
        @(negedge clk);
        chk("rst2_level", level, 4'd0);
        chk("rst2_start", start, 1'b0);
        chk("rst2_busy", busy, 1'b0);
        chk("rst2_in_ready", in_ready, 1'b1);
        chk("rst2_err_timeout", err_timeout, 1'b0);
        chk("rst2_err_spurious", err_spurious, 1'b0);
        chk("rst2_retired", retired_cnt, 16'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst2_idle_start", start, 1'b0);
        chk("rst2_idle_busy", busy, 1'b0);
        push_op(18'h0ABCD, 1'b1, 8'h5A, 8'hC3, 4, 1'b0);
        wait_drain(20);
        chk("rst2_retired_after", retired_cnt, 16'd1);
        chk("rst2_res_mem", res_mem, 8'h5A);

        repeat (2) @(negedge clk);
        chk("instr_queue_empty", exp_instr.size(), 0);
        chk("result_queue_empty", exp_res.size(), 0);
        chk("rsp_queue_empty", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
